serial_addsub_ctrl: RTL and testbench

Bit-serial add/subtract/negate unit that time-shares a single `fulladder` cell across all operand bits instead of instantiating one cell per bit. A small FSM sequences operands LSB-first through the cell and holds carry between cycles. It assembles the result in a shift register and raises a one-cycle `done` with carry and signed-overflow flags. It sits beside the combinational two's-complement datapath as the area-minimal arithmetic option for the same 8-bit operand domain.

---
 rtl/addsub_pkg.sv | 22 ++
 rtl/fulladder.sv | 18 +
 rtl/serial_addsub_ctrl.sv | 124 ++++++++++++
 tb/tb_serial_addsub_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared definitions for the bit-serial add/subtract unit: FSM states,
// operation codes and the default operand width.
`default_nettype none

package addsub_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_NEG  = 2'b10;
  localparam logic [1:0] OP_PASS = 2'b11;

endpackage

`default_nettype wire

// File: rtl/fulladder.sv
// Single-bit full adder cell.
// It is shared by every bit position of the serial datapath.
`default_nettype none

module fulladder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic Y,
  output logic Carry
);

  assign Y     = A ^ B ^ Cin;
  assign Carry = (A & B) | (Cin & (A ^ B));

endmodule

`default_nettype wire

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/sub/negate/pass unit: one full-adder cell, operands fed LSB-first,
// carry held between cycles, result assembled in a right-shifting register.
`default_nettype none

module serial_addsub_ctrl
  import addsub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow
);

  localparam int IDXW = $clog2(WIDTH);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WIDTH - 1);

  state_t           state_q;
  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] y_q;
  logic [WIDTH-1:0] sr_q;
  logic [IDXW-1:0]  bit_idx_q;
  logic             carry_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] result_q;
  logic             carry_out_q;
  logic             overflow_q;

  logic fa_sum;
  logic fa_carry;

  fulladder u_fa (
    .A     (x_q[0]),
    .B     (y_q[0]),
    .Cin   (carry_q),
    .Y     (fa_sum),
    .Carry (fa_carry)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      sr_q        <= '0;
      bit_idx_q   <= '0;
      carry_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            // Subtract and negate are folded into an add of inverted operands plus one.
            case (op)
              OP_ADD:  begin x_q <= a;  y_q <= b;  carry_q <= 1'b0; end
              OP_SUB:  begin x_q <= a;  y_q <= ~b; carry_q <= 1'b1; end
              OP_NEG:  begin x_q <= ~a; y_q <= '0; carry_q <= 1'b1; end
              default: begin x_q <= a;  y_q <= '0; carry_q <= 1'b0; end
            endcase
            bit_idx_q   <= '0;
            sr_q        <= '0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= RUN;
          end
        end

        RUN: begin
          x_q     <= x_q >> 1;
          y_q     <= y_q >> 1;
          carry_q <= fa_carry;
          sr_q    <= {fa_sum, sr_q[WIDTH-1:1]};
          if (bit_idx_q == LAST_IDX) begin
            // carry_q here is the carry into the MSB cell.
            result_q    <= {fa_sum, sr_q[WIDTH-1:1]};
            carry_out_q <= fa_carry;
            overflow_q  <= carry_q ^ fa_carry;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            state_q     <= DONE;
          end else begin
            bit_idx_q <= bit_idx_q + 1'b1;
          end
        end

        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end

        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign carry_out = carry_out_q;
  assign overflow  = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_addsub_ctrl.sv
// Directed self-checking bench for serial_addsub_ctrl (WIDTH=8).
`default_nettype none

module tb_serial_addsub_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         carry_out;
  logic         overflow;

  int total = 0;
  int bad   = 0;

  serial_addsub_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  // Called #1 after a rising edge with the DUT in IDLE. Returns the number of
  // edges from acceptance to the done sample, busy-high samples, and whether
  // busy and done were ever seen together.
  task automatic do_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       output int lat, output int bcnt, output bit both, output bit tmo);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = ~x; b = ~y; op = ~o;
    lat = 0; bcnt = busy ? 1 : 0; both = 1'b0; tmo = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      lat++;
      if (busy) bcnt++;
      if (busy && done) both = 1'b1;
      if (done) begin tmo = 1'b0; break; end
    end
  endtask

  task automatic check_op(input string name, input logic [1:0] o, input logic [W-1:0] x,
                          input logic [W-1:0] y, input logic [W-1:0] er, input logic ec,
                          input logic ev);
    int lat, bcnt; bit both, tmo;
    do_op(o, x, y, lat, bcnt, both, tmo);
    total++;
    if (tmo !== 1'b0) begin bad++; $display("FAIL %s timeout: no done within 40 cycles", name); end
    total++;
    if (result !== er) begin bad++; $display("FAIL %s result: got %h want %h", name, result, er); end
    total++;
    if (carry_out !== ec) begin bad++; $display("FAIL %s carry_out: got %b want %b", name, carry_out, ec); end
    total++;
    if (overflow !== ev) begin bad++; $display("FAIL %s overflow: got %b want %b", name, overflow, ev); end
    total++;
    if (both !== 1'b0) begin bad++; $display("FAIL %s busy_done_overlap: got %b want 0", name, both); end
    @(posedge clk); #1;
    total++;
    if (done !== 1'b0) begin bad++; $display("FAIL %s done_width: got %b want 0", name, done); end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0; start = 1'b0;
    total++;
    if ({busy, done, carry_out, overflow} !== 4'b0000) begin
      bad++; $display("FAIL reset_flags: got %b want 0000", {busy, done, carry_out, overflow});
    end
    total++;
    if (result !== 8'h00) begin bad++; $display("FAIL reset_result: got %h want 00", result); end
    @(posedge clk); #1;
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_start_dropped: busy got %b want 0", busy); end
  endtask

  task automatic test_add();
    int lat, bcnt; bit both, tmo;
    do_op(2'b00, 8'h05, 8'h03, lat, bcnt, both, tmo);
    total++;
    if (lat !== W) begin bad++; $display("FAIL add_latency: got %0d edges want %0d", lat, W); end
    total++;
    if (bcnt !== W) begin bad++; $display("FAIL add_busy_cycles: got %0d want %0d", bcnt, W); end
    total++;
    if ({result, carry_out, overflow} !== {8'h08, 1'b0, 1'b0}) begin
      bad++; $display("FAIL add_05_03: got %h c=%b v=%b want 08 c=0 v=0", result, carry_out, overflow);
    end
    @(posedge clk); #1;
    total++;
    if (result !== 8'h08) begin bad++; $display("FAIL add_result_hold: got %h want 08", result); end
    check_op("add_7f_01", 2'b00, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1);
    check_op("add_ff_01", 2'b00, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_sub();
    check_op("sub_05_07", 2'b01, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0);
    check_op("sub_80_01", 2'b01, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1);
  endtask

  task automatic test_neg_pass();
    check_op("neg_80", 2'b10, 8'h80, 8'h55, 8'h80, 1'b0, 1'b1);
    check_op("neg_00", 2'b10, 8'h00, 8'hAA, 8'h00, 1'b1, 1'b0);
    check_op("neg_01", 2'b10, 8'h01, 8'h12, 8'hFF, 1'b0, 1'b0);
    check_op("pass_3c", 2'b11, 8'h3C, 8'hFF, 8'h3C, 1'b0, 1'b0);
  endtask

  task automatic test_ignore_start();
    bit seen = 1'b0;
    op = 2'b00; a = 8'h05; b = 8'h03; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      start = (i == 3);
      op = 2'b01; a = 8'hFF; b = 8'hFF;
      @(posedge clk); #1;
      start = 1'b0;
      if (done) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b1) begin bad++; $display("FAIL ignore_timeout: done seen %b want 1", seen); end
    total++;
    if (result !== 8'h08) begin bad++; $display("FAIL ignore_run_start: result %h want 08", result); end
    start = 1'b1; op = 2'b00; a = 8'h40; b = 8'h40;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({busy, done} !== 2'b00) begin bad++; $display("FAIL ignore_done_start: busy/done %b want 00", {busy, done}); end
    total++;
    if (result !== 8'h08) begin bad++; $display("FAIL ignore_done_result: got %h want 08", result); end
  endtask

  task automatic test_back_to_back();
    int lat, bcnt; bit both, tmo;
    do_op(2'b00, 8'h10, 8'h20, lat, bcnt, both, tmo);
    total++;
    if (result !== 8'h30) begin bad++; $display("FAIL b2b_first: got %h want 30", result); end
    @(posedge clk); #1;
    do_op(2'b00, 8'h01, 8'h02, lat, bcnt, both, tmo);
    total++;
    if (lat !== W || tmo) begin bad++; $display("FAIL b2b_second_latency: got %0d want %0d", lat, W); end
    total++;
    if (result !== 8'h03) begin bad++; $display("FAIL b2b_second: got %h want 03", result); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    bit saw_done = 1'b0;
    op = 2'b00; a = 8'h05; b = 8'h03; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    total++;
    if ({busy, done, carry_out, overflow} !== 4'b0000) begin
      bad++; $display("FAIL reset_mid_flags: got %b want 0000", {busy, done, carry_out, overflow});
    end
    total++;
    if (result !== 8'h00) begin bad++; $display("FAIL reset_mid_result: got %h want 00", result); end
    for (int i = 0; i < W + 3; i++) begin
      @(posedge clk); #1;
      if (done || busy) saw_done = 1'b1;
    end
    total++;
    if (saw_done !== 1'b0) begin bad++; $display("FAIL reset_mid_ghost: activity %b want 0", saw_done); end
    check_op("after_reset_add", 2'b00, 8'h22, 8'h11, 8'h33, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_neg_pass();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
